nibble_serial_subtractor: RTL and testbench

Multi-cycle, nibble-serial subtractor computing D = A − B − Bin over WIDTH/4 clock cycles, one 4-bit borrow-lookahead slice per cycle. It is the inverse-direction companion to the team's 4-bit carry-lookahead adder, reusing the same slice architecture with inverted operand and borrow polarity. It sits behind a start/done handshake so datapath controllers can trade area for latency on wide subtractions.

---
 rtl/arith_pkg.sv | 19 +
 rtl/nibble_serial_subtractor_if.sv | 25 ++
 rtl/cla_sub4.sv | 29 ++
 rtl/nibble_serial_subtractor.sv | 118 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial datapath.
// Slice width, FSM state encoding and the index-width helper.
package arith_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Slice-index width: clog2(width/4), never below one bit.
    function automatic int idx_width(input int w);
        int n;
        n = w / NIBBLE;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Start/done request bundle between a controller and the subtractor.
// The controller drives operands; the subtractor returns status and result.
interface nibble_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, V
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, V
    );
endinterface

// File: rtl/cla_sub4.sv
// 4-bit borrow-lookahead subtract slice: d = a - b - bin.
// Adder lookahead with b inverted and carry-in taken as ~bin.
module cla_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Flat lookahead carries, no ripple through the slice.
    always_comb begin
        g    = a & ~b;
        p    = a ^ ~b;
        c[0] = ~bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        d    = p ^ c[3:0];
        bout = ~c[4];
    end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle A - B - Bin, one borrow-lookahead nibble per clock.
// Single slice time-multiplexed by the index counter k.
module nibble_serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst,
    nibble_serial_subtractor_if.slave bus
);
    localparam int N   = WIDTH / NIBBLE;
    localparam int KW  = idx_width(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             done_q, done_d;

    logic [3:0]       sa;
    logic [3:0]       sb;
    logic [3:0]       sd;
    logic             sbout;
    logic             last;
    logic             accept;

    assign sa     = a_q[int'(k_q) * NIBBLE +: NIBBLE];
    assign sb     = b_q[int'(k_q) * NIBBLE +: NIBBLE];
    assign last   = (k_q == KW'(N - 1));
    assign accept = (state_q == IDLE) && bus.start;

    cla_sub4 u_slice (
        .a    (sa),
        .b    (sb),
        .bin  (borrow_q),
        .d    (sd),
        .bout (sbout)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    // Next state: start only counts in IDLE; RUN ends after the top slice.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch on accept, then fold one slice per RUN cycle.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        v_d      = v_q;
        done_d   = 1'b0;
        if (accept) begin
            a_d      = bus.A;
            b_d      = bus.B;
            borrow_d = bus.Bin;
            acc_d    = '0;
            k_d      = '0;
        end else if (state_q == RUN) begin
            acc_d[int'(k_q) * NIBBLE +: NIBBLE] = sd;
            borrow_d = sbout;
            k_d      = k_q + 1'b1;
            if (last) begin
                k_d    = '0;
                bout_d = sbout;
                v_d    = (a_q[MSB] != b_q[MSB]) && (sd[3] != a_q[MSB]);
                done_d = 1'b1;
            end
        end
    end

    // Outputs: busy follows the state, everything else is registered.
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = done_q;
        bus.D    = acc_q;
        bus.Bout = bout_q;
        bus.V    = v_q;
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed checks for the nibble-serial subtractor at WIDTH=16.
// Vector table plus hand-written multi-cycle sequences.
module tb_nibble_serial_subtractor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        v;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done, check latency and results.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        int busy_bad;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = v.a;
        bus.B     = v.b;
        bus.Bin   = v.bin;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'hdead;
        bus.B     = 16'hbeef;
        bus.Bin   = ~v.bin;
        chk({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
        lat      = 0;
        busy_bad = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
            if (!bus.busy) busy_bad++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " busy_run"}, 32'(busy_bad), 32'd0);
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, " D"}, 32'(bus.D), 32'(v.d));
        chk({tag, " Bout"}, 32'(bus.Bout), 32'(v.bout));
        chk({tag, " V"}, 32'(bus.V), 32'(v.v));
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, " D_hold"}, 32'(bus.D), 32'(v.d));
    endtask

    initial begin
        int   ndone;
        int   lat;
        vec_t v1;
        vec_t v2;

        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        vecs[9] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst D", 32'(bus.D), 32'd0);
        chk("rst Bout", 32'(bus.Bout), 32'd0);
        chk("rst V", 32'(bus.V), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i], $sformatf("vec%0d", i));

        // start pulsed mid-RUN with other operands is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h1234;
        bus.B     = 16'h0034;
        bus.Bin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'hFFFF;
        bus.B     = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        lat   = 0;
        for (int j = 2; j <= 12; j++) begin
            if (j > 2) @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (lat == 0) lat = j;
                chk("ign D", 32'(bus.D), 32'h1200);
            end
        end
        chk("ign done_count", 32'(ndone), 32'd1);
        chk("ign latency", 32'(lat), 32'd4);

        // Back-to-back: start held through the done cycle.
        v1 = vecs[3];
        v2 = vecs[0];
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = v1.a;
        bus.B     = v1.b;
        bus.Bin   = v1.bin;
        @(negedge clk);
        bus.A     = v2.a;
        bus.B     = v2.b;
        bus.Bin   = v2.bin;
        lat = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
        end
        chk("b2b first_latency", 32'(lat), 32'd4);
        chk("b2b first_D", 32'(bus.D), 32'(v1.d));
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b busy_next", 32'(bus.busy), 32'd1);
        chk("b2b done_next", 32'(bus.done), 32'd0);
        lat = 0;
        for (int j = 2; j <= 12; j++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = j;
                break;
            end
        end
        chk("b2b second_gap", 32'(lat), 32'd5);
        chk("b2b second_D", 32'(bus.D), 32'(v2.d));
        chk("b2b second_V", 32'(bus.V), 32'(v2.v));

        // Reset on the second RUN edge aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 16'h0000;
        bus.B     = 16'h0001;
        bus.Bin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort D", 32'(bus.D), 32'd0);
        chk("abort Bout", 32'(bus.Bout), 32'd0);
        chk("abort V", 32'(bus.V), 32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        run_op(vecs[4], "post_abort");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
